// File: rtl/adc_serial_responder.sv
// Target end of the 3-wire ADC setup port: oversamples sclk/sload/sdata on clk
// and serves an 8 x 9-bit register file with serial write and read-back.
module adc_serial_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [8:0] RST_VAL     = 9'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        sload,
  input  logic        sdata_i,
  output logic        sdata_o,
  output logic        sdata_oe,
  output logic [71:0] reg_q,
  output logic        wr_stb,
  output logic [2:0]  wr_addr,
  output logic [8:0]  wr_data,
  output logic        frame_err
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sclk_sync, sload_sync, sdata_sync, vld;
  logic       sclk_d, sload_d, armed;
  logic       sclk_s, sload_s, sdata_s;
  logic       sclk_rise, sclk_fall, sload_rise, sload_fall;
  logic [4:0] bitcnt;
  logic [8:0] shreg;
  logic       rw;
  logic [2:0] addr;
  logic [8:0] rd_word;
  logic [3:0] rd_idx;
  logic [2:0] addr_now;
  logic [8:0] regs [8];

  // Synchronizers plus one delay stage for edge detection. After reset the
  // block stays disarmed until it has genuinely sampled sload high, so a
  // frame interrupted by reset is never resumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync  <= '0;
      sload_sync <= '1;
      sdata_sync <= '0;
      sclk_d     <= 1'b0;
      sload_d    <= 1'b1;
      vld        <= '0;
      armed      <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      sload_sync <= {sload_sync[SYNC_STAGES-2:0], sload};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata_i};
      sclk_d     <= sclk_sync[SYNC_STAGES-1];
      sload_d    <= sload_sync[SYNC_STAGES-1];
      vld        <= {vld[SYNC_STAGES-2:0], 1'b1};
      armed      <= armed | (vld[SYNC_STAGES-1] & sload_sync[SYNC_STAGES-1]);
    end
  end

  assign sclk_s     = sclk_sync[SYNC_STAGES-1];
  assign sload_s    = sload_sync[SYNC_STAGES-1];
  assign sdata_s    = sdata_sync[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s & ~sclk_d;
  assign sclk_fall  = ~sclk_s & sclk_d;
  assign sload_rise = sload_s & ~sload_d;
  assign sload_fall = ~sload_s & sload_d & armed;
  assign rd_idx     = 4'd15 - bitcnt[3:0];
  assign addr_now   = {shreg[1:0], sdata_s};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (sload_fall) state_n = SHIFT;
      SHIFT:   if (sload_rise) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= RST_VAL;
      bitcnt    <= '0;
      shreg     <= '0;
      rw        <= 1'b0;
      addr      <= '0;
      rd_word   <= '0;
      sdata_o   <= 1'b0;
      sdata_oe  <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_stb    <= 1'b0;
      frame_err <= 1'b0;
      if (state == IDLE) begin
        if (sload_fall) begin
          bitcnt <= '0;
          shreg  <= '0;
          rw     <= 1'b0;
        end
      end else if (sload_rise) begin
        // Frame end wins over a coincident sclk edge.
        sdata_oe <= 1'b0;
        sdata_o  <= 1'b0;
        if (bitcnt == 5'd16) begin
          if (rw) begin
            regs[addr] <= shreg;
            wr_stb     <= 1'b1;
            wr_addr    <= addr;
            wr_data    <= shreg;
          end
        end else begin
          frame_err <= 1'b1;
        end
      end else if (sclk_rise) begin
        shreg <= {shreg[7:0], sdata_s};
        if (bitcnt != 5'd17) bitcnt <= bitcnt + 5'd1;
        if (bitcnt == 5'd0) rw <= sdata_s;
        if (bitcnt == 5'd3) begin
          addr    <= addr_now;
          rd_word <= regs[addr_now];
        end
      end else if (sclk_fall && !rw && bitcnt >= 5'd7 && bitcnt <= 5'd15) begin
        sdata_o  <= rd_word[rd_idx];
        sdata_oe <= 1'b1;
      end
    end
  end

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < 8; i++) reg_q[9*i +: 9] = regs[i];
  end

endmodule

// File: tb/tb_adc_serial_responder.sv
// Directed frames into adc_serial_responder; expected commits, errors and
// read-back words are queued by the driver and checked by monitors.
module tb_adc_serial_responder;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        sload = 1'b1;
  logic        sdata_i = 1'b0;
  logic        sdata_o, sdata_oe, wr_stb, frame_err;
  logic [71:0] reg_q;
  logic [2:0]  wr_addr;
  logic [8:0]  wr_data;

  adc_serial_responder #(.SYNC_STAGES(S), .RST_VAL(9'h000)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .sload(sload), .sdata_i(sdata_i),
    .sdata_o(sdata_o), .sdata_oe(sdata_oe), .reg_q(reg_q), .wr_stb(wr_stb),
    .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  int rise_cyc = 0;
  logic [11:0] exp_q[$];
  int          err_q[$];
  logic [8:0]  rd_q[$];
  logic [8:0]  model[8];

  function automatic void check(string name, logic [71:0] act, logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [71:0] model_flat();
    logic [71:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) f[9*i +: 9] = model[i];
    return f;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame of nrise sclk pulses; rst_after>0 pulses rst after that rise.
  task automatic frame(input logic rw, input logic [2:0] a, input logic [8:0] d,
                       input int nrise, input int rst_after);
    logic [15:0] w;
    w = {rw, a, 3'b000, d};
    if (rst_after == 0) begin
      if (nrise != 16) err_q.push_back(1);
      else if (rw) exp_q.push_back({a, d});
      else rd_q.push_back(model[a]);
    end
    sload = 1'b0;
    wait_clk(6);
    for (int i = 0; i < nrise; i++) begin
      sdata_i = (i < 16) ? w[15-i] : 1'b0;
      wait_clk(5);
      sclk = 1'b1;
      wait_clk(5);
      sclk = 1'b0;
      if (rst_after == i + 1) begin
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
      end
    end
    wait_clk(5);
    sload = 1'b1;
    rise_cyc = cyc;
    wait_clk(10);
    if (rst_after != 0) for (int i = 0; i < 8; i++) model[i] = 9'h000;
    else if (nrise == 16 && rw) model[a] = d;
    check("reg_q_after_frame", reg_q, model_flat());
    check("sdata_oe_idle", sdata_oe, 1'b0);
  endtask

  // Write-commit and frame-error monitor
  always @(negedge clk) begin
    if (wr_stb) begin
      if (exp_q.size() == 0) check("wr_unexpected", wr_stb, 1'b0);
      else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e[11:9]);
        check("wr_data", wr_data, e[8:0]);
        check("wr_latency", cyc - rise_cyc, S + 1);
      end
    end
    if (frame_err) begin
      if (err_q.size() == 0) check("err_unexpected", frame_err, 1'b0);
      else begin
        void'(err_q.pop_front());
        check("err_latency", cyc - rise_cyc, S + 1);
      end
    end
  end

  // Read-back monitor: initiator samples sdata_o on sclk rises while enabled
  int         rd_n = 0;
  logic [8:0] rd_acc = '0;
  always @(posedge sclk) begin
    if (sdata_oe === 1'b1) begin
      rd_acc = {rd_acc[7:0], sdata_o};
      rd_n++;
    end
  end
  always @(posedge sload) begin
    if (rd_q.size() != 0) begin
      logic [8:0] e;
      e = rd_q.pop_front();
      check("rd_bits", rd_n, 9);
      check("rd_data", rd_acc, e);
    end else if (rd_n != 0) begin
      check("rd_unexpected", rd_n, 0);
    end
    rd_n = 0;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL timeout: got no finish expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    for (int i = 0; i < 8; i++) model[i] = 9'h000;
    wait_clk(4);
    check("rst_reg_q", reg_q, 72'h0);
    check("rst_wr_stb", wr_stb, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_sdata_oe", sdata_oe, 1'b0);
    check("rst_sdata_o", sdata_o, 1'b0);
    check("rst_wr_addr", wr_addr, 3'd0);
    check("rst_wr_data", wr_data, 9'h0);
    rst = 1'b0;
    wait_clk(8);

    frame(1'b1, 3'd5, 9'h1A5, 16, 0);
    check("reg5_slice", reg_q[53:45], 9'h1A5);
    frame(1'b1, 3'd2, 9'h0F3, 16, 0);
    frame(1'b0, 3'd2, 9'h000, 16, 0);
    frame(1'b1, 3'd1, 9'h1FF, 10, 0);
    check("reg1_after_abort", reg_q[17:9], 9'h000);
    frame(1'b1, 3'd1, 9'h001, 16, 0);
    frame(1'b1, 3'd3, 9'h0AA, 17, 0);
    frame(1'b1, 3'd6, 9'h155, 9, 9);
    check("reg6_after_rst", reg_q[62:54], 9'h000);
    frame(1'b1, 3'd6, 9'h0C3, 16, 0);
    frame(1'b1, 3'd0, 9'h1FF, 16, 0);
    frame(1'b1, 3'd7, 9'h100, 16, 0);
    check("reg0_slice", reg_q[8:0], 9'h1FF);
    check("reg7_slice", reg_q[71:63], 9'h100);

    wait_clk(10);
    check("wr_q_drained", exp_q.size(), 0);
    check("err_q_drained", err_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
